lpc_host: RTL and testbench
===========================

LPC_HOST -- requirements
Module: lpc_host

Interface
REQ-001 SHALL have parameter SYNC_NORESP_MAX, default 3: consecutive SYNC cycles with no valid SYNC code before abort.
REQ-002 SHALL have parameter WAIT_MAX, default 255: maximum total SYNC-phase cycles before abort.
REQ-003 SHALL have port clk_i  in  1  LPC clock (LCLK); the only clock.
REQ-004 SHALL have port nrst_i  in  1  reset, synchronous, active-low.
REQ-005 SHALL have port req_i  in  1  request strobe; accepted only when busy_o=0.
REQ-006 SHALL have port req_tpm_i  in  1  1: TPM cycle (START=0101); 0: I/O cycle (START=0000).
REQ-007 SHALL have port req_wr_i  in  1  1: write; 0: read.
REQ-008 SHALL have port req_addr_i  in  16  target address.
REQ-009 SHALL have port req_data_i  in  8  write data.
REQ-010 SHALL have port busy_o  out  1  transaction in progress.
REQ-011 SHALL have port done_o  out  1  one-cycle completion pulse.
REQ-012 SHALL have port err_o  out  1  completion status; valid while done_o=1.
REQ-013 SHALL have port rdata_o  out  8  read data; held until the next done_o.
REQ-014 SHALL have port lframe_o  out  1  LFRAME pin level (active low).
REQ-015 SHALL have port lad_o  out  4  LAD drive value.
REQ-016 SHALL have port lad_oe_o  out  4->1  LAD output enable, width 1.
REQ-017 SHALL have port lad_i  in  4  LAD sampled value.

Function
REQ-018 SHALL latch req_tpm_i, req_wr_i, req_addr_i and req_data_i on the accepting edge; busy_o SHALL rise the following cycle.
REQ-019 SHALL sequence the bus through these states: IDLE, START, CYCTYPE, ADDR (4 cycles), WDATA (2 cycles, write only), HTAR (2 cycles), SYNC (1 or more cycles), RDATA (2 cycles, read only), PTAR (2 cycles), ABORT (4 cycles), then back to IDLE.
REQ-020 START: lframe_o=0, lad_o = 0101 for TPM cycles, 0000 for I/O cycles; lframe_o SHALL be 1 in every other non-ABORT state.
REQ-021 CYCTYPE: lad_o = 0000 for read, 0010 for write.
REQ-022 ADDR: address nibbles SHALL be driven MSN first ([15:12] down to [3:0]); WDATA SHALL drive data[3:0] then data[7:4].
REQ-023 lad_oe_o SHALL be 1 from START through the first HTAR cycle (which drives lad_o=1111), and 0 in the second HTAR cycle, SYNC, RDATA, PTAR and IDLE.
REQ-024 SYNC on lad_i: 0000 ends the phase normally; 1010 ends the phase and sets the error flag; 0101 or 0110 means wait (stay in SYNC, reset the no-response count); any other value increments the no-response count.
REQ-025 When the no-response count reaches SYNC_NORESP_MAX, or total SYNC cycles reach WAIT_MAX, the block SHALL enter ABORT.
REQ-026 ABORT: lframe_o=0, lad_oe_o=1, lad_o=1111 for 4 cycles, then IDLE with err_o=1 and rdata_o=8'hFF.
REQ-027 RDATA SHALL capture lad_i as rdata[3:0] then rdata[7:4]; for reads, data SHALL be captured after both 0000 and 1010 SYNC.
REQ-028 done_o and busy_o=0 SHALL occur together in the cycle after the last PTAR or ABORT cycle; a req_i in that cycle SHALL be accepted.
REQ-029 Zero-wait latency: 13 bus cycles after acceptance (read and write alike), with done_o in the 14th cycle.
REQ-030 The no-response count SHALL be at least 2 bits wide and the wait counter 8 bits wide; both SHALL clear on entering SYNC.

Reset
REQ-031 With nrst_i=0 at a clock edge, the block SHALL enter IDLE: lframe_o=1, lad_oe_o=0, lad_o=1111, busy_o=0, done_o=0, err_o=0, rdata_o=8'h00, and all counters cleared.
REQ-032 A reset during a transaction SHALL abandon it with no done_o pulse; req_i SHALL be ignored while nrst_i=0.

Verification
REQ-033 TPM write: addr=16'h0024, data=8'hA5, SYNC=0000 immediately -> LAD 0101,0010,0,0,2,4,5,A,F,(z),(z),(z),(z); done_o at cycle 14; err_o=0.
REQ-034 I/O read: addr=16'h002E, peripheral SYNC=0110 x3 then 0000, data 8'h3C -> LAD nibbles C then 3 observed; done_o at cycle 17; rdata_o=8'h3C; err_o=0.
REQ-035 Read with SYNC=1010 and data 8'h5A -> rdata_o=8'h5A, err_o=1.
REQ-036 No peripheral response (lad_i=1111) -> after 3 SYNC cycles, lframe_o=0 for 4 cycles with LAD=1111; then done_o=1, err_o=1, rdata_o=8'hFF.
REQ-037 Persistent 0110 SYNC -> abort after 255 SYNC cycles; err_o=1.
REQ-038 nrst_i=0 during ADDR -> next cycle lframe_o=1, lad_oe_o=0, busy_o=0; no done_o; a new request afterwards completes normally.

Source files
------------

// File: rtl/lpc_host_if.sv
// Request/completion handshake and LPC pin signals shared by the host and its environment.
// master: the lpc_host itself; slave: the requester and bus-side peer.
interface lpc_host_if;
  logic        req_i;
  logic        req_tpm_i;
  logic        req_wr_i;
  logic [15:0] req_addr_i;
  logic [7:0]  req_data_i;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic [7:0]  rdata_o;
  logic        lframe_o;
  logic [3:0]  lad_o;
  logic        lad_oe_o;
  logic [3:0]  lad_i;

  modport master (
    input  req_i, req_tpm_i, req_wr_i, req_addr_i, req_data_i, lad_i,
    output busy_o, done_o, err_o, rdata_o, lframe_o, lad_o, lad_oe_o
  );

  modport slave (
    output req_i, req_tpm_i, req_wr_i, req_addr_i, req_data_i, lad_i,
    input  busy_o, done_o, err_o, rdata_o, lframe_o, lad_o, lad_oe_o
  );
endinterface

// File: rtl/lpc_host.sv
// LPC host: runs one TPM or I/O read/write cycle per accepted request, 13 bus cycles at zero wait.
// Pin outputs decode straight from the state register; done/err/rdata are registered at completion.
module lpc_host #(
  parameter int SYNC_NORESP_MAX = 3,
  parameter int WAIT_MAX        = 255
) (
  input  logic       clk_i,
  input  logic       nrst_i,
  lpc_host_if.master bus
);

  localparam int NW = ($clog2(SYNC_NORESP_MAX + 1) < 2) ? 2 : $clog2(SYNC_NORESP_MAX + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_CYCTYPE, S_ADDR, S_WDATA,
    S_HTAR, S_SYNC, S_RDATA, S_PTAR, S_ABORT
  } state_t;

  state_t        state, state_nxt;
  logic [1:0]    ph;
  logic          tpm_q, wr_q;
  logic [15:0]   addr_q;
  logic [7:0]    data_q;
  logic [NW-1:0] noresp_cnt;
  logic [7:0]    wait_cnt;
  logic          sync_err;
  logic [7:0]    rdata_sh;
  logic          done_q, err_q;
  logic [7:0]    rdata_q;
  logic          lframe, lad_oe;
  logic [3:0]    lad;
  logic          accept, sync_end, sync_wait, noresp_hit, wait_hit, finishing;

  assign accept     = (state == S_IDLE) && bus.req_i;
  assign sync_end   = (bus.lad_i == 4'b0000) || (bus.lad_i == 4'b1010);
  assign sync_wait  = (bus.lad_i == 4'b0101) || (bus.lad_i == 4'b0110);
  // Limits are judged on the count including the cycle being sampled now
  assign noresp_hit = !sync_wait && ((int'(noresp_cnt) + 1) >= SYNC_NORESP_MAX);
  assign wait_hit   = (int'(wait_cnt) + 1) >= WAIT_MAX;
  assign finishing  = ((state == S_PTAR) || (state == S_ABORT)) && (state_nxt == S_IDLE);

  always_ff @(posedge clk_i) begin
    if (!nrst_i) begin
      state <= S_IDLE;
      ph    <= 2'd0;
    end else begin
      state <= state_nxt;
      ph    <= (state_nxt != state) ? 2'd0 : ph + 2'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    lframe    = 1'b1;
    lad_oe    = 1'b0;
    lad       = 4'hF;
    case (state)
      S_IDLE: begin
        if (accept) state_nxt = S_START;
      end
      S_START: begin
        lframe    = 1'b0;
        lad_oe    = 1'b1;
        lad       = tpm_q ? 4'b0101 : 4'b0000;
        state_nxt = S_CYCTYPE;
      end
      S_CYCTYPE: begin
        lad_oe    = 1'b1;
        lad       = wr_q ? 4'b0010 : 4'b0000;
        state_nxt = S_ADDR;
      end
      S_ADDR: begin
        lad_oe = 1'b1;
        case (ph)
          2'd0:    lad = addr_q[15:12];
          2'd1:    lad = addr_q[11:8];
          2'd2:    lad = addr_q[7:4];
          default: lad = addr_q[3:0];
        endcase
        if (ph == 2'd3) state_nxt = wr_q ? S_WDATA : S_HTAR;
      end
      S_WDATA: begin
        lad_oe = 1'b1;
        lad    = ph[0] ? data_q[7:4] : data_q[3:0];
        if (ph == 2'd1) state_nxt = S_HTAR;
      end
      S_HTAR: begin
        lad_oe = (ph == 2'd0);
        if (ph == 2'd1) state_nxt = S_SYNC;
      end
      S_SYNC: begin
        if (sync_end)                    state_nxt = wr_q ? S_PTAR : S_RDATA;
        else if (noresp_hit || wait_hit) state_nxt = S_ABORT;
      end
      S_RDATA: begin
        if (ph == 2'd1) state_nxt = S_PTAR;
      end
      S_PTAR: begin
        if (ph == 2'd1) state_nxt = S_IDLE;
      end
      S_ABORT: begin
        lframe = 1'b0;
        lad_oe = 1'b1;
        if (ph == 2'd3) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!nrst_i) begin
      tpm_q      <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= 16'h0000;
      data_q     <= 8'h00;
      noresp_cnt <= '0;
      wait_cnt   <= 8'd0;
      sync_err   <= 1'b0;
      rdata_sh   <= 8'h00;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= 8'h00;
    end else begin
      if (accept) begin
        tpm_q    <= bus.req_tpm_i;
        wr_q     <= bus.req_wr_i;
        addr_q   <= bus.req_addr_i;
        data_q   <= bus.req_data_i;
        sync_err <= 1'b0;
      end

      // Counters sit at zero outside SYNC, so they start clean on entry
      if (state == S_SYNC) begin
        wait_cnt   <= wait_cnt + 8'd1;
        noresp_cnt <= sync_wait ? '0 : noresp_cnt + 1'b1;
        if (bus.lad_i == 4'b1010) sync_err <= 1'b1;
      end else begin
        wait_cnt   <= 8'd0;
        noresp_cnt <= '0;
      end

      if (state == S_RDATA) begin
        if (ph == 2'd0) rdata_sh[3:0] <= bus.lad_i;
        else            rdata_sh[7:4] <= bus.lad_i;
      end

      done_q <= finishing;
      if (finishing) begin
        if (state == S_ABORT) begin
          err_q   <= 1'b1;
          rdata_q <= 8'hFF;
        end else begin
          err_q <= sync_err;
          if (!wr_q) rdata_q <= rdata_sh;
        end
      end
    end
  end

  assign bus.busy_o   = (state != S_IDLE);
  assign bus.done_o   = done_q;
  assign bus.err_o    = err_q;
  assign bus.rdata_o  = rdata_q;
  assign bus.lframe_o = lframe;
  assign bus.lad_o    = lad;
  assign bus.lad_oe_o = lad_oe;

endmodule

// File: tb/tb_lpc_host.sv
// Directed and randomized LPC host transactions checked against a cycle-trace model built from the bus rules.
module tb_lpc_host;
  localparam int NORESP = 3;
  localparam int WMAX   = 255;

  typedef struct packed {
    logic       lframe;
    logic       oe;
    logic [3:0] lad;
    logic [3:0] drv;
  } step_t;

  logic clk_i = 1'b0;
  logic nrst_i;
  int   checks = 0;
  int   errors = 0;

  step_t      exp_q[$];
  logic [3:0] sync_plan[$];
  logic [7:0] exp_rdata;
  logic       exp_err;

  lpc_host_if bus ();

  lpc_host #(.SYNC_NORESP_MAX(NORESP), .WAIT_MAX(WMAX)) dut (
    .clk_i (clk_i),
    .nrst_i(nrst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic lf, input logic oe, input logic [3:0] lad, input logic [3:0] drv);
    step_t s;
    s.lframe = lf;
    s.oe     = oe;
    s.lad    = lad;
    s.drv    = drv;
    exp_q.push_back(s);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i);
      check("idle_busy_done", 16'({bus.busy_o, bus.done_o}), 16'h0);
    end
  endtask

  // Expected pin trace for one transaction, then drive it and compare every cycle
  task automatic run_txn(input string tag, input logic tpm, input logic wr,
                         input logic [15:0] addr, input logic [7:0] wdat, input logic [7:0] rdat);
    logic       aborted, serr;
    int         total, noresp;
    logic [3:0] code;
    step_t      s;
    exp_q.delete();
    push(1'b0, 1'b1, tpm ? 4'h5 : 4'h0, 4'hF);
    push(1'b1, 1'b1, wr ? 4'h2 : 4'h0, 4'hF);
    for (int k = 3; k >= 0; k--) push(1'b1, 1'b1, addr[k*4 +: 4], 4'hF);
    if (wr) begin
      push(1'b1, 1'b1, wdat[3:0], 4'hF);
      push(1'b1, 1'b1, wdat[7:4], 4'hF);
    end
    push(1'b1, 1'b1, 4'hF, 4'hF);
    push(1'b1, 1'b0, 4'hF, 4'hF);
    aborted = 1'b0; serr = 1'b0; total = 0; noresp = 0;
    forever begin
      code = (sync_plan.size() > 0) ? sync_plan.pop_front() : 4'hF;
      push(1'b1, 1'b0, 4'hF, code);
      total++;
      if (code == 4'h0 || code == 4'hA) begin
        serr = (code == 4'hA);
        break;
      end
      if (code == 4'h5 || code == 4'h6) noresp = 0;
      else noresp++;
      if (noresp >= NORESP || total >= WMAX) begin
        aborted = 1'b1;
        break;
      end
    end
    sync_plan.delete();
    if (aborted) begin
      repeat (4) push(1'b0, 1'b1, 4'hF, 4'hF);
      exp_err   = 1'b1;
      exp_rdata = 8'hFF;
    end else begin
      if (!wr) begin
        push(1'b1, 1'b0, 4'hF, rdat[3:0]);
        push(1'b1, 1'b0, 4'hF, rdat[7:4]);
        exp_rdata = rdat;
      end
      push(1'b1, 1'b0, 4'hF, 4'hF);
      push(1'b1, 1'b0, 4'hF, 4'hF);
      exp_err = serr;
    end

    bus.req_i      = 1'b1;
    bus.req_tpm_i  = tpm;
    bus.req_wr_i   = wr;
    bus.req_addr_i = addr;
    bus.req_data_i = wdat;
    bus.lad_i      = 4'hF;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk_i);
      bus.req_i      = 1'b0;
      bus.req_addr_i = 16'($urandom);
      bus.req_data_i = 8'($urandom);
      s = exp_q[i];
      check({tag, "_cycle"},
            16'({bus.lframe_o, bus.lad_oe_o, bus.lad_oe_o ? bus.lad_o : 4'h0, bus.busy_o, bus.done_o}),
            16'({s.lframe, s.oe, s.oe ? s.lad : 4'h0, 2'b10}));
      bus.lad_i = s.drv;
    end
    @(negedge clk_i);
    check({tag, "_done"}, 16'({bus.lframe_o, bus.lad_oe_o, bus.busy_o, bus.done_o}), 16'b1001);
    check({tag, "_err"}, 16'(bus.err_o), 16'(exp_err));
    if (!wr || aborted) check({tag, "_rdata"}, 16'(bus.rdata_o), 16'(exp_rdata));
    bus.lad_i = 4'hF;
  endtask

  initial begin
    logic [3:0] codes[8];
    int         n;
    codes = '{4'h5, 4'h6, 4'h6, 4'hF, 4'h3, 4'h9, 4'h5, 4'hC};

    nrst_i         = 1'b0;
    bus.req_i      = 1'b1;
    bus.req_tpm_i  = 1'b1;
    bus.req_wr_i   = 1'b1;
    bus.req_addr_i = 16'h5555;
    bus.req_data_i = 8'h55;
    bus.lad_i      = 4'hF;
    exp_rdata      = 8'h00;
    exp_err        = 1'b0;
    repeat (3) @(negedge clk_i);
    check("rst_lframe", 16'(bus.lframe_o), 16'h1);
    check("rst_lad_oe", 16'(bus.lad_oe_o), 16'h0);
    check("rst_lad", 16'(bus.lad_o), 16'hF);
    check("rst_busy", 16'(bus.busy_o), 16'h0);
    check("rst_done", 16'(bus.done_o), 16'h0);
    check("rst_err", 16'(bus.err_o), 16'h0);
    check("rst_rdata", 16'(bus.rdata_o), 16'h00);
    nrst_i    = 1'b1;
    bus.req_i = 1'b0;
    idle(2);

    sync_plan = '{4'h0};
    run_txn("tpm_wr", 1'b1, 1'b1, 16'h0024, 8'hA5, 8'h00);
    idle(1);

    sync_plan = '{4'h6, 4'h6, 4'h6, 4'h0};
    run_txn("io_rd_wait", 1'b0, 1'b0, 16'h002E, 8'h00, 8'h3C);

    sync_plan = '{4'hA};
    run_txn("rd_syncerr", 1'b0, 1'b0, 16'h0100, 8'h00, 8'h5A);

    run_txn("noresp_abort", 1'b0, 1'b0, 16'h0060, 8'h00, 8'h77);
    idle(2);

    repeat (300) sync_plan.push_back(4'h6);
    run_txn("wait_abort", 1'b1, 1'b0, 16'hBEEF, 8'h00, 8'h11);
    idle(1);

    // Reset mid-ADDR abandons the cycle silently and ignores requests while held
    bus.req_i      = 1'b1;
    bus.req_tpm_i  = 1'b0;
    bus.req_wr_i   = 1'b1;
    bus.req_addr_i = 16'h1234;
    bus.req_data_i = 8'h77;
    @(negedge clk_i);
    bus.req_i = 1'b0;
    repeat (2) @(negedge clk_i);
    check("addr_before_rst", 16'({bus.lframe_o, bus.lad_oe_o, bus.lad_o, bus.busy_o}), 16'b1100011);
    nrst_i    = 1'b0;
    bus.req_i = 1'b1;
    @(negedge clk_i);
    check("rst_mid_addr", 16'({bus.lframe_o, bus.lad_oe_o, bus.busy_o, bus.done_o}), 16'b1000);
    @(negedge clk_i);
    check("rst_req_ignored", 16'({bus.busy_o, bus.done_o}), 16'h0);
    nrst_i    = 1'b1;
    bus.req_i = 1'b0;
    idle(4);
    sync_plan = '{4'h5, 4'h0};
    run_txn("after_rst", 1'b0, 1'b1, 16'hC0DE, 8'h96, 8'h00);

    for (int t = 0; t < 24; t++) begin
      n = $urandom_range(0, 5);
      for (int j = 0; j < n; j++) sync_plan.push_back(codes[$urandom_range(0, 7)]);
      sync_plan.push_back(($urandom_range(0, 3) == 0) ? 4'hA : 4'h0);
      run_txn("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              16'($urandom), 8'($urandom), 8'($urandom));
      idle($urandom_range(0, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
